// File: rtl/capture_dump_ctrl.sv
// Capture RAM dump sequencer: walks the circular capture buffer from the oldest
// sample and hands each byte to the UART. Define DUMP_CHKSUM_EN to append a mod-256 checksum byte.
module capture_dump_ctrl #(
  parameter int DEPTH  = 384,
  parameter int ADDR_W = 9,
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_req,
  input  logic [1:0]        dump_ch,
  input  logic              capture_done,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        ram_rdata,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_ren,
  output logic [1:0]        ram_ch_sel,
  output logic [7:0]        tx_data,
  output logic              trmt,
  output logic              busy,
  output logic              dump_done,
  output logic              dump_nak,
  output logic              clr_cap_done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

`ifdef DUMP_CHKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_WAIT_TX, S_CHK, S_WAIT_CHK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_WAIT_TX, S_DONE
  } state_t;
`endif

  // Handshake: trmt is a one-cycle pulse with tx_data valid in that same cycle;
  // the UART answers with a one-cycle tx_done once the byte has left the line.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [1:0]        ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        txd_q, txd_d;
  logic              nak_q, nak_d;
`ifdef DUMP_CHKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      txd_q   <= '0;
      nak_q   <= 1'b0;
`ifdef DUMP_CHKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      nak_q   <= nak_d;
`ifdef DUMP_CHKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    raddr_d      = raddr_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    txd_d        = txd_q;
    nak_d        = 1'b0;
    ram_ren      = 1'b0;
    trmt         = 1'b0;
    dump_done    = 1'b0;
    clr_cap_done = 1'b0;
    tx_data      = txd_q;
`ifdef DUMP_CHKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (dump_req) begin
          if (capture_done) begin
            // Out-of-range write pointers mean the buffer restarts at 0.
            raddr_d = ({1'b0, waddr} >= DEPTH_C) ? '0 : waddr;
            ch_d    = (32'(dump_ch) < NUM_CH) ? dump_ch : 2'd0;
            cnt_d   = '0;
`ifdef DUMP_CHKSUM_EN
            sum_d   = '0;
`endif
            state_d = S_READ;
          end else begin
            nak_d = 1'b1;
          end
        end
      end
      S_READ: begin
        ram_ren = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // Bypass so the UART sees the fresh byte in the same cycle as trmt.
        trmt    = 1'b1;
        tx_data = ram_rdata;
        txd_d   = ram_rdata;
`ifdef DUMP_CHKSUM_EN
        sum_d   = sum_q + ram_rdata;
`endif
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          cnt_d   = cnt_q + CNT_W'(1);
          raddr_d = (raddr_q == LAST_A) ? '0 : raddr_q + ADDR_W'(1);
          if (cnt_d == DEPTH_C) begin
`ifdef DUMP_CHKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_READ;
          end
        end
      end
`ifdef DUMP_CHKSUM_EN
      S_CHK: begin
        trmt    = 1'b1;
        tx_data = sum_q;
        txd_d   = sum_q;
        state_d = S_WAIT_CHK;
      end
      S_WAIT_CHK: begin
        if (tx_done) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        dump_done    = 1'b1;
        clr_cap_done = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign dump_nak   = nak_q;
  assign ram_raddr  = raddr_q;
  assign ram_ch_sel = ch_q;

endmodule

// File: tb/tb_capture_dump_ctrl.sv
// Bench for capture_dump_ctrl: RAM and UART models, expected-byte scoreboard
// checked by a monitor on the falling clock edge.
module tb_capture_dump_ctrl;
  localparam int DEPTH  = 384;
  localparam int ADDR_W = 9;
  localparam int NUM_CH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              dump_req, capture_done, tx_done;
  logic [1:0]        dump_ch;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        ram_rdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_ren, trmt, busy, dump_done, dump_nak, clr_cap_done;
  logic [1:0]        ram_ch_sel;
  logic [7:0]        tx_data;

  capture_dump_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .dump_ch(dump_ch),
    .capture_done(capture_done), .waddr(waddr), .ram_rdata(ram_rdata),
    .tx_done(tx_done), .ram_raddr(ram_raddr), .ram_ren(ram_ren),
    .ram_ch_sel(ram_ch_sel), .tx_data(tx_data), .trmt(trmt), .busy(busy),
    .dump_done(dump_done), .dump_nak(dump_nak), .clr_cap_done(clr_cap_done)
  );

  // channel RAM model: registered read
  logic [7:0] mem [NUM_CH][512];
  always @(posedge clk) if (ram_ren) ram_rdata <= mem[ram_ch_sel][ram_raddr];

  function automatic logic [7:0] ram_val(input int ch, input int a);
    logic [7:0] k;
    k = 8'(ch ^ 1) * 8'h5A;
    return 8'(a) ^ k;
  endfunction

  // scoreboard state
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                gap_q[$];
  logic [1:0]        exp_ch;
  int checks = 0, errors = 0;
  int trmt_cnt = 0, done_cnt = 0, exp_done = 0;
  int req_cyc = 0, last_tx_cyc = 0, tx_delay = 10;
  bit first_pending = 0;
  logic [7:0] last_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART model: answer each trmt with tx_done tx_delay clocks later
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && trmt) begin
        repeat (tx_delay) @(posedge clk);
        #1 tx_done = 1'b1;
        last_tx_cyc = cyc;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // monitor
  always @(negedge clk) begin : monitor
    logic [7:0] eb;
    logic [ADDR_W-1:0] ea;
    int g;
    if (rst_n) begin
      if (ram_ren) begin
        if (exp_addr_q.size() == 0) check("spurious ram_ren", 32'(ram_ren), 32'd0);
        else begin
          ea = exp_addr_q.pop_front();
          check("read addr", 32'(ram_raddr), 32'(ea));
          check("ren ch_sel", 32'(ram_ch_sel), 32'(exp_ch));
        end
      end
      if (trmt) begin
        trmt_cnt++;
        if (exp_q.size() == 0) check("spurious trmt", 32'(trmt), 32'd0);
        else begin
          eb = exp_q.pop_front();
          g  = gap_q.pop_front();
          check("tx byte", 32'(tx_data), 32'(eb));
          check("trmt ch_sel", 32'(ram_ch_sel), 32'(exp_ch));
          if (first_pending) begin
            // cycles counted inclusively from the request cycle
            check("accept to trmt", 32'(cyc - req_cyc + 1), 32'd3);
            first_pending = 0;
          end else begin
            check("tx_done to trmt", 32'(cyc - last_tx_cyc), 32'(g));
          end
          last_byte = tx_data;
        end
      end
      if (dump_done || clr_cap_done) begin
        check("clr with done", 32'(clr_cap_done), 32'(dump_done));
        check("bytes left at done", 32'(exp_q.size()), 32'd0);
        check("done after tx_done", 32'(cyc - last_tx_cyc), 32'd1);
        done_cnt++;
      end
    end
  end

  // driver tasks
  task automatic pulse_req(input int ch, input int wa, input logic cap, output int rc);
    @(posedge clk);
    #1;
    dump_ch = 2'(ch); waddr = ADDR_W'(wa); capture_done = cap; dump_req = 1'b1;
    rc = cyc;
    @(posedge clk);
    #1 dump_req = 1'b0;
  endtask

  task automatic start_dump(input int ch, input int wa);
    int a, rc;
    logic [7:0] sum;
    a = (wa >= DEPTH) ? 0 : wa;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_addr_q.push_back(ADDR_W'(a));
      exp_q.push_back(mem[ch][a]);
      gap_q.push_back(2);
      sum = sum + mem[ch][a];
      a = (a == DEPTH - 1) ? 0 : a + 1;
    end
`ifdef DUMP_CHKSUM_EN
    exp_q.push_back(sum);
    gap_q.push_back(1);
`endif
    exp_ch = 2'(ch);
    exp_done++;
    @(negedge clk);
    first_pending = 1;
    pulse_req(ch, wa, 1'b1, rc);
    req_cyc = rc;
    @(negedge clk);
    check("busy after accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_trmts(input int n);
    int budget;
    budget = 20000;
    while (trmt_cnt < n && budget > 0) begin @(negedge clk); budget--; end
    check("trmt count reached", 32'(trmt_cnt >= n), 32'd1);
  endtask

  task automatic wait_done();
    int budget;
    budget = DEPTH * (tx_delay + 6) + 200;
    while (done_cnt < exp_done && budget > 0) begin @(negedge clk); budget--; end
    check("dump completions", 32'(done_cnt), 32'(exp_done));
    @(negedge clk);
    check("busy after done", 32'(busy), 32'd0);
  endtask

  initial begin
    int rc, base;
    rst_n = 1'b0; dump_req = 1'b0; dump_ch = '0; capture_done = 1'b0; waddr = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < 512; a++) mem[c][a] = ram_val(c, a);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst trmt", 32'(trmt), 32'd0);
    check("rst ram_ren", 32'(ram_ren), 32'd0);
    check("rst raddr", 32'(ram_raddr), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst ch_sel", 32'(ram_ch_sel), 32'd0);
    check("rst pulses", 32'({dump_done, dump_nak, clr_cap_done}), 32'd0);
    #1 rst_n = 1'b1;

    // basic dump: ch1 holds addr[7:0], UART answers after 10 clocks
    tx_delay = 10;
    start_dump(1, 0);
    wait_done();
    check("basic last byte", 32'(last_byte), 32'h7F);

    // wrap from the last entry, then out-of-range waddr
    tx_delay = 3;
    start_dump(0, DEPTH - 1);
    wait_done();
    start_dump(3, 450);
    wait_done();

    // request with no capture available
    pulse_req(2, 0, 1'b0, rc);
    @(negedge clk);
    check("nak pulse", 32'(dump_nak), 32'd1);
    check("nak busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("nak width", 32'(dump_nak), 32'd0);
    check("nak busy later", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // second request and capture_done drop while busy are ignored
    start_dump(1, 100);
    base = trmt_cnt;
    wait_trmts(base + 50);
    pulse_req(3, 7, 1'b1, rc);
    @(negedge clk);
    check("no nak while busy", 32'(dump_nak), 32'd0);
    check("ch_sel held", 32'(ram_ch_sel), 32'd1);
    capture_done = 1'b0;
    wait_done();
    capture_done = 1'b1;

    // reset in the middle of a dump, then a fresh dump
    start_dump(0, 200);
    base = trmt_cnt;
    wait_trmts(base + 100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst trmt", 32'(trmt), 32'd0);
    check("mid rst ram_ren", 32'(ram_ren), 32'd0);
    check("mid rst raddr", 32'(ram_raddr), 32'd0);
    check("mid rst clr", 32'(clr_cap_done), 32'd0);
    exp_q.delete(); exp_addr_q.delete(); gap_q.delete();
    first_pending = 0;
    exp_done--;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("no done after reset", 32'(done_cnt), 32'(exp_done));
    start_dump(2, 5);
    wait_done();

`ifdef DUMP_CHKSUM_EN
    for (int a = 0; a < 512; a++) mem[2][a] = 8'h01;
    start_dump(2, 0);
    wait_done();
    check("checksum byte", 32'(last_byte), 32'h80);
`endif

    repeat (5) @(negedge clk);
    check("no leftover reads", 32'(exp_addr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/capture_dump_ctrl.md
Name: capture_dump_ctrl

Overview:
- Sequences readout of the capture RAM after the capture unit asserts capture_done.
- Walks the circular buffer from the oldest sample (current waddr) for DEPTH entries of the selected channel.
- Hands each byte to the UART transmitter through a trmt/tx_done handshake.
- On completion, pulses clr_cap_done to re-arm capture (clears TrigCfg[5] upstream).

Parameters:
- DEPTH, 384, number of sample entries per channel RAM.
- ADDR_W, 9, address width; must satisfy 2**ADDR_W >= DEPTH.
- NUM_CH, 4, number of channel RAMs selectable by dump_ch.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- dump_req  input  1  single-cycle request to start a dump
- dump_ch  input  2  channel to dump; sampled with dump_req
- capture_done  input  1  level from capture unit; buffer is full and stable
- waddr  input  ADDR_W  capture unit next-write address (= oldest sample)
- ram_rdata  input  8  read data; valid one cycle after ram_ren
- tx_done  input  1  UART single-cycle pulse: byte transmitted
- ram_raddr  output  ADDR_W  RAM read address
- ram_ren  output  1  RAM read enable
- ram_ch_sel  output  2  channel RAM select; held for the whole dump
- tx_data  output  8  byte to UART
- trmt  output  1  single-cycle pulse: start UART transmission of tx_data
- busy  output  1  high from accept until return to IDLE
- dump_done  output  1  single-cycle pulse at end of dump
- dump_nak  output  1  single-cycle pulse: request rejected
- clr_cap_done  output  1  single-cycle pulse, same cycle as dump_done

Behaviour:
- Reset: state IDLE. All outputs 0; ram_raddr 0; internal counter 0.
- IDLE:
  - dump_req with capture_done=1: latch ram_raddr<=waddr and ram_ch_sel<=dump_ch, clear the counter, go to READ. busy rises on the next edge.
  - dump_req with capture_done=0: pulse dump_nak next cycle; stay in IDLE.
- READ: ram_ren=1 for exactly one cycle; go to LATCH.
- LATCH: tx_data<=ram_rdata; trmt=1 for one cycle; go to WAIT_TX.
- WAIT_TX: hold tx_data. On tx_done:
  - Increment the counter. ram_raddr <= (ram_raddr==DEPTH-1) ? 0 : ram_raddr+1.
  - If the counter reaches DEPTH, go to DONE; else go to READ.
- DONE: dump_done=1 and clr_cap_done=1 for one cycle; go to IDLE; busy falls.
- Latency: accept to first trmt = 3 clocks (IDLE→READ→LATCH, trmt asserted in LATCH). tx_done to next trmt = 2 clocks.
- Wrap: waddr=DEPTH-1 must read DEPTH-1, 0, 1, …, DEPTH-2. waddr values >= DEPTH are treated as 0.
- Ignored inputs:
  - dump_req while busy: no nak, no restart.
  - tx_done outside WAIT_TX.
  - Changes on dump_ch and waddr after accept.
- capture_done dropping mid-dump: the dump continues; it is not aborted.
- Counter width: ADDR_W+1 bits; terminal compare is exact equality to DEPTH.
- Reset mid-dump: immediate return to IDLE. trmt, ram_ren and the pulse outputs drop asynchronously. No clr_cap_done is issued.

Optional Feature:
- Macro: DUMP_CHKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of every transmitted sample byte is kept, cleared on accept.
  - After the DEPTH-th tx_done, state CHK loads tx_data<=sum and pulses trmt. State WAIT_CHK waits for tx_done, then goes to DONE.
  - Total bytes per dump = DEPTH+1.
- Undefined: no sum logic and no CHK/WAIT_CHK states; exactly DEPTH bytes per dump.

Test Plan:
- Basic dump:
  - Stimulus: RAM ch1 preloaded with addr[7:0]; waddr=0; capture_done=1; dump_ch=1; dump_req; tx_done returned 10 clocks after each trmt.
  - Required: 384 trmt pulses with bytes 0x00..0xFF then 0x00..0x7F; ram_ch_sel=1 throughout; dump_done and clr_cap_done coincident, exactly once.
- Wrap:
  - Stimulus: waddr=383.
  - Required: first read address 383, second 0, last 382; 384 reads total.
- Nak:
  - Stimulus: capture_done=0 with dump_req.
  - Required: dump_nak pulses 1 cycle; busy stays 0; no ram_ren, no trmt.
- Busy ignore and latency:
  - Stimulus: second dump_req (dump_ch=3) issued mid-dump.
  - Required: ram_ch_sel unchanged; still exactly 384 bytes; first trmt 3 clocks after the first accept.
- Reset mid-dump:
  - Stimulus: rst_n low after byte 100, then a fresh request.
  - Required: outputs 0 immediately; no clr_cap_done; restarted dump sends 384 bytes starting at the new waddr.
- Checksum (DUMP_CHKSUM_EN defined):
  - Stimulus: all samples 0x01.
  - Required: 385th byte = 384 mod 256 = 0x80; dump_done pulses only after its tx_done.
